wr_ingress: RTL and testbench

- Write-side ingress stage of the async FIFO; sits directly upstream of the write-pointer/full block in the write clock domain.
- Accepts a valid/ready stream and buffers it in a 2-entry skid buffer, so the registered, one-cycle-late full flag never drops data.
- Drives wr_inc/wr_data into the FIFO and reports write-side fill level and almost-full, using the synchronized gray read pointer.

---
 rtl/wr_ingress_if.sv | 27 ++
 rtl/wr_ingress.sv | 139 +++++++++++++
 tb/tb_wr_ingress.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/wr_ingress_if.sv
// rtl/wr_ingress_if.sv - upstream stream and write-pointer/full block signals of the write ingress stage
interface wr_ingress_if #(
  parameter int ADDR_SIZE = 4,
  parameter int DATA_SIZE = 8
);
  logic                 s_valid;
  logic [DATA_SIZE-1:0] s_data;
  logic                 s_ready;
  logic                 wr_full;
  logic [ADDR_SIZE:0]   wr_ptr;
  logic [ADDR_SIZE:0]   wr_q2_rptr;
  logic                 wr_inc;
  logic [DATA_SIZE-1:0] wr_data;
  logic [ADDR_SIZE:0]   wr_level;
  logic                 wr_afull;
  logic                 wr_err;

  modport master (
    output s_valid, s_data, wr_full, wr_ptr, wr_q2_rptr,
    input  s_ready, wr_inc, wr_data, wr_level, wr_afull, wr_err
  );

  modport slave (
    input  s_valid, s_data, wr_full, wr_ptr, wr_q2_rptr,
    output s_ready, wr_inc, wr_data, wr_level, wr_afull, wr_err
  );
endinterface

// File: rtl/wr_ingress.sv
// rtl/wr_ingress.sv - write-side skid buffer feeding the async FIFO, plus write-side level/almost-full/error
module wr_ingress #(
  parameter int ADDR_SIZE    = 4,
  parameter int DATA_SIZE    = 8,
  parameter int AFULL_THRESH = 12
) (
  input logic         wr_clk,
  input logic         wr_rst,
  wr_ingress_if.slave bus
);
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [ADDR_SIZE:0] AFULL_LVL = AFULL_THRESH[ADDR_SIZE:0];
  localparam logic [ADDR_SIZE:0] DEPTH_LVL = {1'b1, {ADDR_SIZE{1'b0}}};

  state_t               state;
  state_t               state_next;
  logic                 s_ready_q;
  logic [DATA_SIZE-1:0] head;
  logic [DATA_SIZE-1:0] tail;
  logic                 push;
  logic                 pop;
  logic                 load_head_in;
  logic                 load_tail_in;
  logic                 load_head_tail;

  logic [ADDR_SIZE:0]   wbin;
  logic [ADDR_SIZE:0]   rbin;
  logic [ADDR_SIZE:0]   diff;
  logic [ADDR_SIZE:0]   level_q;
  logic                 afull_q;
  logic                 err_q;

  function automatic logic [ADDR_SIZE:0] gray2bin(input logic [ADDR_SIZE:0] g);
    logic [ADDR_SIZE:0] b;
    b = g;
    for (int i = ADDR_SIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // s_ready is registered from next_state so the full flag's one-cycle lag is absorbed by the second slot
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      state     <= EMPTY;
      s_ready_q <= 1'b0;
    end else begin
      state     <= state_next;
      s_ready_q <= (state_next != TWO);
    end
  end

  always_comb begin
    state_next     = state;
    load_head_in   = 1'b0;
    load_tail_in   = 1'b0;
    load_head_tail = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          state_next   = ONE;
          load_head_in = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          load_head_in = 1'b1;
        end else if (push) begin
          state_next   = TWO;
          load_tail_in = 1'b1;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_next     = ONE;
          load_head_tail = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // pop uses the same accept term as the pointer block, so every strobe is a committed write
  always_comb begin
    push         = bus.s_valid & s_ready_q;
    pop          = (state != EMPTY) & ~bus.wr_full;
    bus.s_ready  = s_ready_q;
    bus.wr_inc   = pop;
    bus.wr_data  = head;
  end

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (load_head_in) begin
        head <= bus.s_data;
      end else if (load_head_tail) begin
        head <= tail;
      end
      if (load_tail_in) begin
        tail <= bus.s_data;
      end
    end
  end

  // Modular subtraction handles pointer wrap; a difference beyond the depth means corrupt pointers
  always_comb begin
    wbin = gray2bin(bus.wr_ptr);
    rbin = gray2bin(bus.wr_q2_rptr);
    diff = wbin - rbin;
  end

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      level_q <= '0;
      afull_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      level_q <= diff;
      afull_q <= (diff >= AFULL_LVL);
      if (diff > DEPTH_LVL) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.wr_level = level_q;
  assign bus.wr_afull = afull_q;
  assign bus.wr_err   = err_q;
endmodule

// File: tb/tb_wr_ingress.sv
// tb/tb_wr_ingress.sv - directed self-checking bench for wr_ingress
module tb_wr_ingress;
  logic wr_clk = 1'b0;
  logic wr_rst;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] wlog[$];

  wr_ingress_if #(.ADDR_SIZE(4), .DATA_SIZE(8)) bus ();

  wr_ingress #(.ADDR_SIZE(4), .DATA_SIZE(8), .AFULL_THRESH(12)) dut (
    .wr_clk (wr_clk),
    .wr_rst (wr_rst),
    .bus    (bus)
  );

  always #5 wr_clk = ~wr_clk;

  // Every negedge with wr_inc high precedes a committed write at the next edge
  always @(negedge wr_clk) begin
    if (bus.wr_inc === 1'b1) wlog.push_back(bus.wr_data);
  end

  task automatic set_ptrs(input int wb, input int rb);
    logic [4:0] w;
    logic [4:0] r;
    w = 5'(wb);
    r = 5'(rb);
    bus.wr_ptr     = w ^ (w >> 1);
    bus.wr_q2_rptr = r ^ (r >> 1);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge wr_clk);
    @(negedge wr_clk);
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %0h want 0", bus.s_ready); end
    checks++; if (bus.wr_inc !== 1'b0) begin errors++; $display("FAIL reset_wr_inc: got %0h want 0", bus.wr_inc); end
    checks++; if (bus.wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data: got %0h want 0", bus.wr_data); end
    checks++; if (bus.wr_level !== 5'd0) begin errors++; $display("FAIL reset_wr_level: got %0d want 0", bus.wr_level); end
    checks++; if (bus.wr_afull !== 1'b0) begin errors++; $display("FAIL reset_wr_afull: got %0h want 0", bus.wr_afull); end
    checks++; if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL reset_wr_err: got %0h want 0", bus.wr_err); end
  endtask

  task automatic test_stream();
    logic [7:0] exp;
    @(posedge wr_clk); #1 wr_rst = 1'b0;
    @(negedge wr_clk);
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL release_s_ready_early: got %0h want 0", bus.s_ready); end
    @(posedge wr_clk); #1;
    bus.s_valid = 1'b1; bus.s_data = 8'h01; wlog.delete();
    @(negedge wr_clk);
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL release_s_ready: got %0h want 1", bus.s_ready); end
    checks++; if (bus.wr_inc !== 1'b0) begin errors++; $display("FAIL stream_no_inc_before_accept: got %0h want 0", bus.wr_inc); end
    for (int i = 1; i <= 5; i++) begin
      @(posedge wr_clk); #1;
      if (i < 5) bus.s_data = 8'(i + 1);
      else bus.s_valid = 1'b0;
      @(negedge wr_clk);
      exp = 8'(i);
      checks++; if (bus.wr_inc !== 1'b1) begin errors++; $display("FAIL stream_inc[%0d]: got %0h want 1", i, bus.wr_inc); end
      checks++; if (bus.wr_data !== exp) begin errors++; $display("FAIL stream_data[%0d]: got %0h want %0h", i, bus.wr_data, exp); end
      checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %0h want 1", i, bus.s_ready); end
    end
    @(posedge wr_clk); #1;
    @(negedge wr_clk);
    checks++; if (bus.wr_inc !== 1'b0) begin errors++; $display("FAIL stream_drained: got %0h want 0", bus.wr_inc); end
    checks++; if (wlog.size() !== 5) begin errors++; $display("FAIL stream_count: got %0d want 5", wlog.size()); end
    for (int i = 0; i < 5; i++) begin
      exp = 8'(i + 1);
      checks++;
      if (wlog.size() <= i || wlog[i] !== exp) begin
        errors++; $display("FAIL stream_order[%0d]: got %0h want %0h", i, (wlog.size() > i) ? wlog[i] : 8'hxx, exp);
      end
    end
  endtask

  task automatic test_full_hold();
    logic [7:0] exp;
    @(posedge wr_clk); #1;
    bus.wr_full = 1'b1; bus.s_valid = 1'b1; bus.s_data = 8'hA0; wlog.delete();
    @(negedge wr_clk);
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL full_ready0: got %0h want 1", bus.s_ready); end
    @(posedge wr_clk); #1 bus.s_data = 8'hA1;
    @(negedge wr_clk);
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL full_ready1: got %0h want 1", bus.s_ready); end
    checks++; if (bus.wr_inc !== 1'b0) begin errors++; $display("FAIL full_inc1: got %0h want 0", bus.wr_inc); end
    checks++; if (bus.wr_data !== 8'hA0) begin errors++; $display("FAIL full_head1: got %0h want a0", bus.wr_data); end
    @(posedge wr_clk); #1 bus.s_data = 8'hA2;
    @(negedge wr_clk);
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL full_ready2: got %0h want 0", bus.s_ready); end
    checks++; if (bus.wr_inc !== 1'b0) begin errors++; $display("FAIL full_inc2: got %0h want 0", bus.wr_inc); end
    @(posedge wr_clk); #1;
    @(negedge wr_clk);
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL full_ready3: got %0h want 0", bus.s_ready); end
    checks++; if (bus.wr_data !== 8'hA0) begin errors++; $display("FAIL full_head3: got %0h want a0", bus.wr_data); end
    @(posedge wr_clk); #1 bus.wr_full = 1'b0;
    @(negedge wr_clk);
    checks++; if (bus.wr_inc !== 1'b1 || bus.wr_data !== 8'hA0) begin errors++; $display("FAIL drain0: got inc=%0h data=%0h want inc=1 data=a0", bus.wr_inc, bus.wr_data); end
    @(posedge wr_clk); #1;
    @(negedge wr_clk);
    checks++; if (bus.wr_inc !== 1'b1 || bus.wr_data !== 8'hA1) begin errors++; $display("FAIL drain1: got inc=%0h data=%0h want inc=1 data=a1", bus.wr_inc, bus.wr_data); end
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL drain_ready: got %0h want 1", bus.s_ready); end
    @(posedge wr_clk); #1 bus.s_valid = 1'b0;
    @(negedge wr_clk);
    checks++; if (bus.wr_inc !== 1'b1 || bus.wr_data !== 8'hA2) begin errors++; $display("FAIL drain2: got inc=%0h data=%0h want inc=1 data=a2", bus.wr_inc, bus.wr_data); end
    @(posedge wr_clk); #1;
    @(negedge wr_clk);
    checks++; if (bus.wr_inc !== 1'b0) begin errors++; $display("FAIL drain_empty: got %0h want 0", bus.wr_inc); end
    checks++; if (wlog.size() !== 3) begin errors++; $display("FAIL full_count: got %0d want 3", wlog.size()); end
    for (int i = 0; i < 3; i++) begin
      exp = 8'hA0 + 8'(i);
      checks++;
      if (wlog.size() <= i || wlog[i] !== exp) begin
        errors++; $display("FAIL full_order[%0d]: got %0h want %0h", i, (wlog.size() > i) ? wlog[i] : 8'hxx, exp);
      end
    end
  endtask

  task automatic test_level();
    @(posedge wr_clk); #1 set_ptrs(13, 0);
    @(negedge wr_clk);
    checks++; if (bus.wr_level !== 5'd0) begin errors++; $display("FAIL level_lag: got %0d want 0", bus.wr_level); end
    @(negedge wr_clk);
    checks++; if (bus.wr_level !== 5'd13) begin errors++; $display("FAIL level_13: got %0d want 13", bus.wr_level); end
    checks++; if (bus.wr_afull !== 1'b1) begin errors++; $display("FAIL afull_13: got %0h want 1", bus.wr_afull); end
    @(posedge wr_clk); #1 set_ptrs(13, 1);
    @(negedge wr_clk); @(negedge wr_clk);
    checks++; if (bus.wr_level !== 5'd12 || bus.wr_afull !== 1'b1) begin errors++; $display("FAIL level_12: got level=%0d afull=%0h want 12 1", bus.wr_level, bus.wr_afull); end
    @(posedge wr_clk); #1 set_ptrs(13, 2);
    @(negedge wr_clk); @(negedge wr_clk);
    checks++; if (bus.wr_level !== 5'd11 || bus.wr_afull !== 1'b0) begin errors++; $display("FAIL level_11: got level=%0d afull=%0h want 11 0", bus.wr_level, bus.wr_afull); end
    @(posedge wr_clk); #1 set_ptrs(3, 25);
    @(negedge wr_clk); @(negedge wr_clk);
    checks++; if (bus.wr_level !== 5'd10 || bus.wr_afull !== 1'b0) begin errors++; $display("FAIL level_wrap: got level=%0d afull=%0h want 10 0", bus.wr_level, bus.wr_afull); end
    checks++; if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL err_wrap: got %0h want 0", bus.wr_err); end
    @(posedge wr_clk); #1 set_ptrs(16, 0);
    @(negedge wr_clk); @(negedge wr_clk);
    checks++; if (bus.wr_level !== 5'd16 || bus.wr_afull !== 1'b1) begin errors++; $display("FAIL level_16: got level=%0d afull=%0h want 16 1", bus.wr_level, bus.wr_afull); end
    checks++; if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL err_at_depth: got %0h want 0", bus.wr_err); end
  endtask

  task automatic test_error();
    @(posedge wr_clk); #1 set_ptrs(20, 0);
    @(negedge wr_clk);
    checks++; if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL err_lag: got %0h want 0", bus.wr_err); end
    @(negedge wr_clk);
    checks++; if (bus.wr_err !== 1'b1) begin errors++; $display("FAIL err_set: got %0h want 1", bus.wr_err); end
    @(posedge wr_clk); #1 set_ptrs(0, 0);
    repeat (3) @(negedge wr_clk);
    checks++; if (bus.wr_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %0h want 1", bus.wr_err); end
    checks++; if (bus.wr_level !== 5'd0) begin errors++; $display("FAIL level_legal_again: got %0d want 0", bus.wr_level); end
  endtask

  task automatic test_reset_mid();
    @(posedge wr_clk); #1;
    set_ptrs(5, 0); bus.wr_full = 1'b1; bus.s_valid = 1'b1; bus.s_data = 8'hB0;
    @(posedge wr_clk); #1 bus.s_data = 8'hB1;
    @(posedge wr_clk); #1;
    @(negedge wr_clk);
    checks++; if (bus.s_ready !== 1'b0 || bus.wr_level !== 5'd5) begin errors++; $display("FAIL pre_reset_two: got ready=%0h level=%0d want 0 5", bus.s_ready, bus.wr_level); end
    @(posedge wr_clk); #1 bus.wr_full = 1'b0;
    #1;
    checks++; if (bus.wr_inc !== 1'b1) begin errors++; $display("FAIL pre_reset_inc: got %0h want 1", bus.wr_inc); end
    #1 wr_rst = 1'b1; bus.s_valid = 1'b0;
    #1;
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready: got %0h want 0", bus.s_ready); end
    checks++; if (bus.wr_inc !== 1'b0) begin errors++; $display("FAIL mid_reset_inc: got %0h want 0", bus.wr_inc); end
    checks++; if (bus.wr_level !== 5'd0) begin errors++; $display("FAIL mid_reset_level: got %0d want 0", bus.wr_level); end
    checks++; if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL mid_reset_err: got %0h want 0", bus.wr_err); end
    checks++; if (bus.wr_data !== 8'h00) begin errors++; $display("FAIL mid_reset_data: got %0h want 0", bus.wr_data); end
    set_ptrs(0, 0);
    @(posedge wr_clk); #1 wr_rst = 1'b0; wlog.delete();
    @(posedge wr_clk); #1 bus.s_valid = 1'b1; bus.s_data = 8'hC5;
    @(negedge wr_clk);
    checks++; if (bus.s_ready !== 1'b1 || bus.wr_inc !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got ready=%0h inc=%0h want 1 0", bus.s_ready, bus.wr_inc); end
    @(posedge wr_clk); #1 bus.s_valid = 1'b0;
    @(negedge wr_clk);
    checks++; if (bus.wr_inc !== 1'b1 || bus.wr_data !== 8'hC5) begin errors++; $display("FAIL post_reset_first: got inc=%0h data=%0h want 1 c5", bus.wr_inc, bus.wr_data); end
    @(posedge wr_clk); #1;
    @(posedge wr_clk); #1;
    @(negedge wr_clk);
    checks++; if (bus.wr_inc !== 1'b0) begin errors++; $display("FAIL post_reset_drained: got %0h want 0", bus.wr_inc); end
    checks++;
    if (wlog.size() !== 1 || wlog[0] !== 8'hC5) begin
      errors++; $display("FAIL post_reset_log: got size=%0d first=%0h want 1 c5", wlog.size(), (wlog.size() > 0) ? wlog[0] : 8'hxx);
    end
  endtask

  initial begin
    wr_rst         = 1'b1;
    bus.s_valid    = 1'b0;
    bus.s_data     = 8'h00;
    bus.wr_full    = 1'b0;
    bus.wr_ptr     = 5'd0;
    bus.wr_q2_rptr = 5'd0;
    test_reset();
    test_stream();
    test_full_hold();
    test_level();
    test_error();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
